// File: rtl/pie_frame_decoder.sv
// pie_frame_decoder
//
// Gen2-style PIE frame receiver. The raw line is synchronised and
// deglitched, then the delimiter, Tari, RTcal and optional TRcal symbols are
// measured. Data bits are sliced against a pivot of RTcal/2.
//
// Ports
//   clk          clock
//   rst_n        synchronous active-low reset
//   in_pie       raw PIE line (asynchronous), high = carrier, low = pulse
//   out_bit      decoded bit, valid while out_valid
//   out_valid    one-cycle strobe per decoded data bit
//   frame_start  one-cycle strobe when calibration is accepted
//   frame_done   one-cycle strobe on clean end of frame
//   frame_err    one-cycle strobe on frame abort
//   preamble     1 = TRcal present in the current/last frame
//   rtcal_o      measured RTcal, held until the next frame_start
//   trcal_o      measured TRcal, 0 when the frame had none
//   bit_count    bits emitted in the current frame, saturating
//
// State  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for the falling edge that opens a delimiter
// DELIM  | line low, measuring the delimiter
// TARI   | measuring the data-0 (Tari) reference symbol
// RTCAL  | measuring RTcal, validated against Tari
// FIRST  | first symbol after RTcal: TRcal or first data bit
// DATA   | slicing data bits until end of frame or error

`timescale 1ns/1ps

module pie_frame_decoder #(
    parameter int CNT_W     = 8,
    parameter int FILT      = 2,
    parameter int DELIM_MIN = 16,
    parameter int DELIM_MAX = 24,
    parameter int BITS_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_pie,
    output logic              out_bit,
    output logic              out_valid,
    output logic              frame_start,
    output logic              frame_done,
    output logic              frame_err,
    output logic              preamble,
    output logic [CNT_W-1:0]  rtcal_o,
    output logic [CNT_W-1:0]  trcal_o,
    output logic [BITS_W-1:0] bit_count
);

    // Calibration arithmetic runs three bits wider than the counters so
    // products up to 5x a full-scale count never wrap.
    localparam int W      = CNT_W + 3;
    localparam int STAB_W = (FILT > 1) ? $clog2(FILT) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [BITS_W-1:0] BITS_MAX = '1;
    localparam logic [W-1:0]      DMIN_W   = W'(DELIM_MIN);
    localparam logic [W-1:0]      DMAX_W   = W'(DELIM_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELIM,
        S_TARI,
        S_RTCAL,
        S_FIRST,
        S_DATA
    } state_e;

    // ------------------------------------------------------------------
    // Front end: synchroniser, stability filter, interval counters
    // ------------------------------------------------------------------
    logic              sync1_q, sync2_q;
    logic              lvl_q, lvl_d;
    logic              lvl_d1_q;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  sym_q, sym_d;
    logic              rise_ev, fall_ev;

    // lvl_d1_q is the level of the interval that an event ends, so the
    // timeout checks below see the old level in the event cycle.
    assign rise_ev =  lvl_q & ~lvl_d1_q;
    assign fall_ev = ~lvl_q &  lvl_d1_q;

    always_comb begin
        lvl_d  = lvl_q;
        stab_d = '0;
        if (sync2_q != lvl_q) begin
            if (stab_q == STAB_W'(FILT - 1)) begin
                lvl_d = sync2_q;
            end else begin
                stab_d = stab_q + STAB_W'(1);
            end
        end
    end

    // cnt: event-to-event length; sym: rise-to-rise symbol length.
    always_comb begin
        cnt_d = cnt_q;
        if (rise_ev || fall_ev) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        sym_d = sym_q;
        if (rise_ev) begin
            sym_d = CNT_W'(1);
        end else if (sym_q != CNT_MAX) begin
            sym_d = sym_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            lvl_q    <= 1'b1;
            lvl_d1_q <= 1'b1;
            stab_q   <= '0;
            cnt_q    <= '0;
            sym_q    <= '0;
        end else begin
            sync1_q  <= in_pie;
            sync2_q  <= sync1_q;
            lvl_q    <= lvl_d;
            lvl_d1_q <= lvl_q;
            stab_q   <= stab_d;
            cnt_q    <= cnt_d;
            sym_q    <= sym_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM with registered outputs
    // ------------------------------------------------------------------
    state_e            state_q;
    logic [CNT_W-1:0]  tari_q;
    logic [CNT_W-1:0]  pivot_q;
    logic [CNT_W-1:0]  rtcal_q;
    logic [CNT_W-1:0]  trcal_q;
    logic [BITS_W-1:0] bit_count_q;
    logic              preamble_q;
    logic              out_bit_q;
    logic              out_valid_q;
    logic              frame_start_q;
    logic              frame_done_q;
    logic              frame_err_q;

    logic [W-1:0] cnt_w, sym_w, tari_w, rt_w, pivot_w;
    logic [W-1:0] rt2_w, rt3_w, tari3_w, tari5_w, sym2_w;
    logic         cnt_sat, sym_sat;

    assign cnt_w   = W'(cnt_q);
    assign sym_w   = W'(sym_q);
    assign tari_w  = W'(tari_q);
    assign rt_w    = W'(rtcal_q);
    assign pivot_w = W'(pivot_q);
    assign rt2_w   = rt_w << 1;
    assign rt3_w   = rt2_w + rt_w;
    assign tari3_w = (tari_w << 1) + tari_w;
    assign tari5_w = (tari_w << 2) + tari_w;
    assign sym2_w  = sym_w << 1;
    // A saturated counter no longer holds a true length; treat it as
    // beyond every limit.
    assign cnt_sat = (cnt_q == CNT_MAX);
    assign sym_sat = (sym_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            tari_q        <= '0;
            pivot_q       <= '0;
            rtcal_q       <= '0;
            trcal_q       <= '0;
            bit_count_q   <= '0;
            preamble_q    <= 1'b0;
            out_bit_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (fall_ev) begin
                        state_q <= S_DELIM;
                    end
                end

                S_DELIM: begin
                    if (rise_ev) begin
                        if (!cnt_sat && cnt_w >= DMIN_W && cnt_w <= DMAX_W) begin
                            state_q <= S_TARI;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end

                S_TARI, S_RTCAL: begin
                    // Timeouts take priority over an event in the same cycle.
                    if (!lvl_d1_q && (cnt_w > DMAX_W || cnt_sat)) begin
                        frame_err_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else if (lvl_d1_q && cnt_sat) begin
                        frame_err_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else if (rise_ev) begin
                        if (state_q == S_TARI) begin
                            tari_q  <= sym_q;
                            state_q <= S_RTCAL;
                        end else if (!sym_sat && sym2_w >= tari5_w && sym_w <= tari3_w) begin
                            rtcal_q       <= sym_q;
                            pivot_q       <= CNT_W'((sym_w + W'(1)) >> 1);
                            bit_count_q   <= '0;
                            frame_start_q <= 1'b1;
                            state_q       <= S_FIRST;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end
                    end
                end

                S_FIRST, S_DATA: begin
                    if (lvl_d1_q && (cnt_w >= rt2_w || cnt_sat)) begin
                        frame_done_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else if (!lvl_d1_q && (cnt_w > rt_w || cnt_sat)) begin
                        frame_err_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else if (rise_ev) begin
                        if (!sym_sat && sym_w <= rt_w) begin
                            out_valid_q <= 1'b1;
                            out_bit_q   <= (sym_w >= pivot_w);
                            if (bit_count_q != BITS_MAX) begin
                                bit_count_q <= bit_count_q + BITS_W'(1);
                            end
                            if (state_q == S_FIRST) begin
                                preamble_q <= 1'b0;
                                trcal_q    <= '0;
                            end
                            state_q <= S_DATA;
                        end else if (state_q == S_FIRST && !sym_sat && sym_w <= rt3_w) begin
                            trcal_q    <= sym_q;
                            preamble_q <= 1'b1;
                            state_q    <= S_DATA;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out_bit     = out_bit_q;
    assign out_valid   = out_valid_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign frame_err   = frame_err_q;
    assign preamble    = preamble_q;
    assign rtcal_o     = rtcal_q;
    assign trcal_o     = trcal_q;
    assign bit_count   = bit_count_q;

endmodule
